fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- F-stage program-counter unit of the five-stage MIPS CPU with precise exceptions; sits directly upstream of the F/D pipeline register.
- Holds the fetch PC and computes next-PC from sequential/branch/jump/exception/eret sources.
- Detects fetch address errors and produces the PC, exception code, delay-slot flag and null-slot request consumed by the F/D register.
- Holds an eret-pending state so an eret seen during a stall is not lost.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- PC_KERNEL, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, exception code for fetch address error.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = pipeline stall, PC holds.
- int_exc_req  in  1  CP0 interrupt/exception request (highest non-reset priority).
- D_npc_sel  in  1  instruction in D redirects (taken branch or jump).
- D_npc  in  32  redirect target from D.
- D_is_bj  in  1  instruction in D is any branch/jump (taken or not).
- D_eret  in  1  instruction in D is eret.
- EPC  in  32  CP0 EPC, eret return address.
- F_PC  out  32  current fetch address (to IM and F/D register).
- F_exc_code  out  5  0 or EXC_ADEL for the current fetch.
- F_DB  out  1  current fetch is in a branch delay slot.
- F_null_slot  out  1  F/D register must load a bubble (instr 0) this cycle.
- F_fetch_cnt  out  32  count of instructions advanced out of F.

Behaviour:
- Reset values: F_PC = PC_RESET, eret state = IDLE, F_fetch_cnt = 0; F_exc_code/F_DB/F_null_slot are combinational, evaluating to 0 at PC_RESET with D inputs low.
- Next-PC priority at each rising edge (first match wins):
  1. reset.
  2. int_exc_req → PC_KERNEL, regardless of en; eret state → IDLE.
  3. eret state PEND and en → EPC; state → IDLE.
  4. D_eret and en → EPC.
  5. D_eret and !en → PC held; state → PEND.
  6. en and D_npc_sel → D_npc.
  7. en → F_PC + 4 (32-bit, wraps mod 2^32, no overflow flag).
  8. Otherwise PC held.
- Eret states:
  - IDLE: normal operation.
  - PEND: eret captured during a stall; the PC redirects to EPC on the first en=1 cycle.
  - EPC is sampled at the redirect edge, not at capture.
- F_null_slot = en & (D_eret | state==PEND) & !int_exc_req. The wrong-path instruction after eret is squashed; eret has no delay slot.
- F_DB = D_is_bj & !D_eret.
- F_exc_code = EXC_ADEL if F_PC[1:0] != 0 or F_PC < IM_BASE or F_PC > IM_LIMIT; else 0.
  - Purely combinational from F_PC; independent of en.
  - The F/D register zeroes the instruction when the code is nonzero.
- Misaligned/out-of-range targets are still loaded into F_PC; the error is reported, never corrected.
- F_fetch_cnt increments by 1 on every edge with en=1 and int_exc_req=0 and reset=0; wraps at 2^32.
- Simultaneous events:
  - int_exc_req together with D_eret or PEND: exception wins; the eret is discarded.
  - D_eret together with D_npc_sel: eret wins.
- Reset mid-stall or in PEND: everything returns to reset values in one cycle.
- Latency: the redirect is visible on F_PC the cycle after the deciding edge; there are no internal bubbles other than F_null_slot.

Test Plan:
- Reset then en=1 for 3 cycles → F_PC = 0x3000, 0x3004, 0x3008, 0x300C; F_fetch_cnt = 3; F_exc_code = 0.
- At F_PC=0x3010: D_is_bj=1, D_npc_sel=1, D_npc=0x3400 → F_DB=1 that cycle; next F_PC=0x3400, F_DB=0.
- D_npc=0x3402 → next F_PC=0x3402, F_exc_code=4. Separately, D_npc=0x7000 → F_exc_code=4.
- en=0, D_eret=1, EPC=0x3050 for 2 cycles → F_PC held, F_null_slot=0. Then en=1, D_eret=0 → F_null_slot=1; next F_PC=0x3050; state IDLE.
- int_exc_req=1 with en=0 and D_eret=1 → next F_PC=0x4180; F_null_slot=0; F_fetch_cnt unchanged.
- F_PC=0xFFFF_FFFC (forced via D_npc), en=1 → next F_PC=0x0000_0000 (wrap), F_exc_code=4. Reset asserted in PEND → F_PC=0x3000, F_fetch_cnt=0.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Handshake bundle between the F-stage PC unit and its neighbours (D stage, CP0, F/D register).
// The master drives the control and redirect inputs; the slave is the PC unit that returns the fetch state.
interface fetch_pc_if;
    logic        en;
    logic        int_exc_req;
    logic        D_npc_sel;
    logic [31:0] D_npc;
    logic        D_is_bj;
    logic        D_eret;
    logic [31:0] EPC;
    logic [31:0] F_PC;
    logic [4:0]  F_exc_code;
    logic        F_DB;
    logic        F_null_slot;
    logic [31:0] F_fetch_cnt;

    modport master (
        output en, int_exc_req, D_npc_sel, D_npc, D_is_bj, D_eret, EPC,
        input  F_PC, F_exc_code, F_DB, F_null_slot, F_fetch_cnt
    );

    modport slave (
        input  en, int_exc_req, D_npc_sel, D_npc, D_is_bj, D_eret, EPC,
        output F_PC, F_exc_code, F_DB, F_null_slot, F_fetch_cnt
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// F-stage program counter: next-PC selection, fetch address-error detection, and an
// eret-pending state so that an eret seen while the pipeline is stalled is not lost.
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] PC_KERNEL = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
    input  logic       clk,
    input  logic       reset,
    fetch_pc_if.slave  bus
);
    localparam logic [0:0] ERET_IDLE = 1'b0;
    localparam logic [0:0] ERET_PEND = 1'b1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [0:0]  eret_q, eret_d;

    // A fetch address is illegal if it is misaligned or outside the instruction memory window.
    function automatic logic fetch_addr_err(input logic [31:0] pc);
        fetch_addr_err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
    endfunction

    // Next-PC and eret-state selection; the first matching source wins.
    always_comb begin
        pc_d   = pc_q;
        eret_d = eret_q;
        if (bus.int_exc_req) begin
            pc_d   = PC_KERNEL;
            eret_d = ERET_IDLE;
        end else if ((eret_q == ERET_PEND) && bus.en) begin
            pc_d   = bus.EPC;
            eret_d = ERET_IDLE;
        end else if (bus.D_eret && bus.en) begin
            pc_d   = bus.EPC;
            eret_d = ERET_IDLE;
        end else if (bus.D_eret) begin
            pc_d   = pc_q;
            eret_d = ERET_PEND;
        end else if (bus.en && bus.D_npc_sel) begin
            pc_d   = bus.D_npc;
        end else if (bus.en) begin
            pc_d   = pc_q + 32'd4;
        end else begin
            pc_d   = pc_q;
        end
    end

    // Fetch counter: an instruction leaves F on every enabled edge that is not preempted by an exception.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.en && !bus.int_exc_req) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= PC_RESET;
            cnt_q  <= 32'd0;
            eret_q <= ERET_IDLE;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            eret_q <= eret_d;
        end
    end

    // The slot after an eret is wrong-path and must be squashed, unless an exception takes over.
    assign bus.F_PC        = pc_q;
    assign bus.F_fetch_cnt = cnt_q;
    assign bus.F_exc_code  = fetch_addr_err(pc_q) ? EXC_ADEL : 5'd0;
    assign bus.F_DB        = bus.D_is_bj & ~bus.D_eret;
    assign bus.F_null_slot = bus.en & (bus.D_eret | (eret_q == ERET_PEND)) & ~bus.int_exc_req;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit: the stimulus queues hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_pc_unit;
    typedef struct {
        int          step;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        db;
        logic        nul;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   step_no;

    fetch_pc_if bus();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the edge and queue the outputs expected during that cycle.
    task automatic step(input logic r, input logic e, input logic ie, input logic sel,
                        input logic [31:0] npc, input logic bj, input logic er,
                        input logic [31:0] epc, input logic [31:0] pc, input logic [4:0] exc,
                        input logic db, input logic nul, input logic [31:0] cnt);
        exp_t x;
        @(posedge clk);
        #1;
        reset           = r;
        bus.en          = e;
        bus.int_exc_req = ie;
        bus.D_npc_sel   = sel;
        bus.D_npc       = npc;
        bus.D_is_bj     = bj;
        bus.D_eret      = er;
        bus.EPC         = epc;
        step_no++;
        x.step = step_no;
        x.pc   = pc;
        x.exc  = exc;
        x.db   = db;
        x.nul  = nul;
        x.cnt  = cnt;
        exp_q.push_back(x);
    endtask

    // Monitor: compare each queued expectation against the DUT on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks += 5;
            if (bus.F_PC !== x.pc) begin
                errors++;
                $display("FAIL step%0d F_PC: got %h expected %h", x.step, bus.F_PC, x.pc);
            end
            if (bus.F_exc_code !== x.exc) begin
                errors++;
                $display("FAIL step%0d F_exc_code: got %0d expected %0d", x.step, bus.F_exc_code, x.exc);
            end
            if (bus.F_DB !== x.db) begin
                errors++;
                $display("FAIL step%0d F_DB: got %b expected %b", x.step, bus.F_DB, x.db);
            end
            if (bus.F_null_slot !== x.nul) begin
                errors++;
                $display("FAIL step%0d F_null_slot: got %b expected %b", x.step, bus.F_null_slot, x.nul);
            end
            if (bus.F_fetch_cnt !== x.cnt) begin
                errors++;
                $display("FAIL step%0d F_fetch_cnt: got %0d expected %0d", x.step, bus.F_fetch_cnt, x.cnt);
            end
        end
    end

    initial begin
        int budget;
        checks  = 0;
        errors  = 0;
        step_no = 0;
        reset           = 1'b1;
        bus.en          = 1'b0;
        bus.int_exc_req = 1'b0;
        bus.D_npc_sel   = 1'b0;
        bus.D_npc       = 32'd0;
        bus.D_is_bj     = 1'b0;
        bus.D_eret      = 1'b0;
        bus.EPC         = 32'd0;
        repeat (2) @(posedge clk);

        //   rst en   int  sel  D_npc         bj   eret EPC           F_PC          exc   DB   null cnt
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3000, 5'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3000, 5'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3004, 5'd0, 1'b0, 1'b0, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3008, 5'd0, 1'b0, 1'b0, 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_300C, 5'd0, 1'b0, 1'b0, 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_300C, 5'd0, 1'b0, 1'b0, 32'd3);
        // taken branch at 0x3010, then misaligned and out-of-range targets
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3400, 1'b1, 1'b0, 32'h0,       32'h0000_3010, 5'd0, 1'b1, 1'b0, 32'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3400, 5'd0, 1'b0, 1'b0, 32'd5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3402, 1'b1, 1'b0, 32'h0,       32'h0000_3404, 5'd0, 1'b1, 1'b0, 32'd6);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3402, 5'd4, 1'b0, 1'b0, 32'd7);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0,       32'h0000_3402, 5'd4, 1'b0, 1'b0, 32'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0,       32'h0000_7000, 5'd4, 1'b0, 1'b0, 32'd8);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 32'h0,       32'h0000_7000, 5'd4, 1'b0, 1'b0, 32'd8);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2FFC, 1'b0, 1'b0, 32'h0,       32'h0000_6FFC, 5'd0, 1'b0, 1'b0, 32'd9);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0,       32'h0000_2FFC, 5'd4, 1'b0, 1'b0, 32'd10);
        // eret during stall: EPC changes while pending, the value at the redirect edge is used
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_1111, 32'h0000_3000, 5'd0, 1'b0, 1'b0, 32'd11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_2222, 32'h0000_3000, 5'd0, 1'b0, 1'b0, 32'd11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3050, 32'h0000_3000, 5'd0, 1'b0, 1'b1, 32'd11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_3050, 5'd0, 1'b0, 1'b0, 32'd12);
        // eret with a simultaneous redirect: eret wins, no delay slot
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3400, 1'b1, 1'b1, 32'h0000_3060, 32'h0000_3054, 5'd0, 1'b0, 1'b1, 32'd13);
        // exception beats a stalled eret and leaves the state idle
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_3070, 32'h0000_3060, 5'd0, 1'b0, 1'b0, 32'd14);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3070, 32'h0000_4180, 5'd0, 1'b0, 1'b0, 32'd14);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3070, 32'h0000_4180, 5'd0, 1'b0, 1'b0, 32'd14);
        // exception beats a pending eret
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_3050, 32'h0000_4184, 5'd0, 1'b0, 1'b0, 32'd15);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3050, 32'h0000_4184, 5'd0, 1'b0, 1'b0, 32'd15);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3050, 32'h0000_4180, 5'd0, 1'b0, 1'b0, 32'd15);
        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       32'h0000_4184, 5'd0, 1'b0, 1'b0, 32'd16);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hFFFF_FFFC, 5'd4, 1'b0, 1'b0, 32'd17);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0000_0000, 5'd4, 1'b0, 1'b0, 32'd18);
        // reset while an eret is pending
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_3050, 32'h0000_0000, 5'd4, 1'b0, 1'b0, 32'd18);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3050, 32'h0000_0000, 5'd4, 1'b0, 1'b1, 32'd18);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3050, 32'h0000_3000, 5'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_3050, 32'h0000_3004, 5'd0, 1'b0, 1'b0, 32'd1);

        budget = 20;
        while ((exp_q.size() > 0) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
